// File: rtl/shifter_seq.sv
// Multi-cycle shift unit: one 1-bit step per clock, valid/ready on both sides.
// Define SHIFTER_SEQ_ROTATE_EN to build ROL/ROR; otherwise those ops pass data through.
`timescale 1ns/1ps

module shifter_seq #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               op,
  input  logic [$clog2(WIDTH)-1:0] amt,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         data_out,
  output logic                     busy
);

  localparam int AMT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [2:0]         op_q, op_d;
  logic [AMT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   stepWork;

  // Reserved ops (and rotates when not built) are treated as pass-through.
  function automatic logic isShiftOp(input logic [2:0] o);
    case (o)
      OP_SLL, OP_SRL, OP_SRA: return 1'b1;
`ifdef SHIFTER_SEQ_ROTATE_EN
      OP_ROL, OP_ROR:         return 1'b1;
`endif
      default:                return 1'b0;
    endcase
  endfunction

  always_comb begin
    stepWork = work_q;
    case (op_q)
      OP_SLL:  stepWork = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  stepWork = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  stepWork = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
`ifdef SHIFTER_SEQ_ROTATE_EN
      OP_ROL:  stepWork = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      OP_ROR:  stepWork = {work_q[0], work_q[WIDTH-1:1]};
`endif
      default: stepWork = work_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    op_d      = op_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = data_in;
          op_d    = op;
          count_d = amt;
          state_d = (isShiftOp(op) && (amt != '0)) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        work_d  = stepWork;
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      op_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      count_q <= count_d;
    end
  end

  assign data_out = work_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Self-checking bench for shifter_seq (WIDTH=16): directed table, random ops
// against a reference model, and a mid-operation reset abort.
`timescale 1ns/1ps

module tb_shifter_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [3:0]  amt;
  logic [15:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  shifter_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .amt       (amt),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  amt;
    logic [15:0] data;
    logic [15:0] expData;
    int          expWait;
    int          hold;
  } vec_t;

  vec_t vecs[10];

`ifdef SHIFTER_SEQ_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  // Reference: whole-word arithmetic on the operand.
  function automatic logic [15:0] refResult(input logic [2:0] o, input logic [3:0] a,
                                            input logic [15:0] d);
    int unsigned n = a;
    logic [15:0] r;
    case (o)
      3'b001:  r = d << n;
      3'b010:  r = d >> n;
      3'b011:  r = $signed(d) >>> n;
      3'b100:  r = (ROT && n != 0) ? ((d << n) | (d >> (16 - n))) : d;
      3'b101:  r = (ROT && n != 0) ? ((d >> n) | (d << (16 - n))) : d;
      default: r = d;
    endcase
    return r;
  endfunction

  // Cycles spent stepping after the accept edge before the result appears.
  function automatic int refWait(input logic [2:0] o, input logic [3:0] a);
    bit shifts = (o == 3'b001) || (o == 3'b010) || (o == 3'b011) ||
                 (ROT && (o == 3'b100 || o == 3'b101));
    return (shifts && a != 0) ? int'(a) : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [3:0] a,
                               input logic [15:0] d, input logic [15:0] expData,
                               input int expWait, input int hold);
    int n;
    int waited;
    int busyCnt;
    int readyHigh;
    int unstable;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    op        = o;
    amt       = a;
    data_in   = d;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'($urandom_range(0, 1));
    op       = 3'($urandom);
    amt      = 4'($urandom);
    data_in  = 16'($urandom);
    @(negedge clk);
    waited    = 0;
    busyCnt   = 0;
    readyHigh = 0;
    while (!out_valid && waited < 40) begin
      if (busy) busyCnt++;
      if (in_ready) readyHigh++;
      @(negedge clk);
      waited++;
    end
    checkOutput("out_valid", 32'(out_valid), 32'd1);
    checkOutput("latency", 32'(waited), 32'(expWait));
    checkOutput("busy_cycles", 32'(busyCnt), 32'(expWait));
    checkOutput("in_ready_in_flight", 32'(readyHigh), 32'd0);
    checkOutput("data_out", 32'(data_out), 32'(expData));
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || data_out !== expData) unstable++;
    end
    if (hold > 0) checkOutput("hold_stable", 32'(unstable), 32'd0);
    checkOutput("in_ready_done", 32'(in_ready), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("out_valid_after_hs", 32'(out_valid), 32'd0);
    checkOutput("in_ready_after_hs", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{3'b001, 4'd1,  16'h8001, 16'h0002, 1,  0};
    vecs[1] = '{3'b011, 4'd3,  16'h8000, 16'hF000, 3,  0};
    vecs[2] = '{3'b010, 4'd15, 16'h8000, 16'h0001, 15, 0};
    vecs[3] = '{3'b001, 4'd0,  16'h1234, 16'h1234, 0,  0};
    vecs[4] = '{3'b010, 4'd4,  16'hFFFF, 16'h0FFF, 4,  5};
`ifdef SHIFTER_SEQ_ROTATE_EN
    vecs[5] = '{3'b100, 4'd4,  16'h8001, 16'h0018, 4,  0};
    vecs[6] = '{3'b101, 4'd1,  16'h0001, 16'h8000, 1,  1};
`else
    vecs[5] = '{3'b100, 4'd4,  16'h8001, 16'h8001, 0,  0};
    vecs[6] = '{3'b101, 4'd1,  16'h0001, 16'h0001, 0,  1};
`endif
    vecs[7] = '{3'b110, 4'd5,  16'hABCD, 16'hABCD, 0,  2};
    vecs[8] = '{3'b000, 4'd7,  16'h5A5A, 16'h5A5A, 0,  0};
    vecs[9] = '{3'b011, 4'd14, 16'h4000, 16'h0001, 14, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    amt       = '0;
    data_in   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_data_out", 32'(data_out), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i].op, vecs[i].amt, vecs[i].data, vecs[i].expData,
                    vecs[i].expWait, vecs[i].hold);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [3:0]  ra;
      logic [15:0] rd;
      ro = 3'($urandom_range(0, 7));
      ra = 4'($urandom_range(0, 15));
      rd = 16'($urandom);
      applyStimulus(ro, ra, rd, refResult(ro, ra, rd), refWait(ro, ra),
                    $urandom_range(0, 2));
    end

    // Abort an SLL amt=8 with a reset pulse during its second cycle.
    @(negedge clk);
    op       = 3'b001;
    amt      = 4'd8;
    data_in  = 16'h00FF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_data_out", 32'(data_out), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(3'b001, 4'd2, 16'h0001, 16'h0004, 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
